// File: rtl/lane_game_sequencer.sv
// Game-flow controller for the two-player lane-crossing game.
// Optional per-turn timeout when TURN_TIMEOUT_EN is defined.
module lane_game_sequencer #(
  parameter int NUM_LANES  = 6,
  parameter int LANE_PITCH = 60,
  parameter int Y_BASE     = 0,
  parameter int WIN_SCORE  = 10,
  parameter int HOLD_TICKS = 32
`ifdef TURN_TIMEOUT_EN
  ,
  parameter int TURN_TICKS = 600
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       hit,
  output logic [1:0] state,
  output logic [2:0] player_lane,
  output logic [9:0] player_y,
  output logic       block_run,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic       turn_start
);

  localparam logic [2:0] START_LANE = 3'(NUM_LANES + 1);
  localparam logic [2:0] LAST_MID   = 3'(NUM_LANES);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam int         HC_W       = $clog2(HOLD_TICKS + 1);
  localparam logic [HC_W-1:0] HC_END = HC_W'(HOLD_TICKS - 1);
`ifdef TURN_TIMEOUT_EN
  localparam int         TC_W       = $clog2(TURN_TICKS + 1);
  localparam logic [TC_W-1:0] TC_END = TC_W'(TURN_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_HOLD,
    S_DONE
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic            p2_q, p2_d;
  logic [2:0]      lane_q, lane_d;
  logic [9:0]      y_q, y_d;
  logic [3:0]      s1_q, s1_d;
  logic [3:0]      s2_q, s2_d;
  logic [1:0]      win_q, win_d;
  logic            ts_q, ts_d;
  logic [HC_W-1:0] hc_q, hc_d;
`ifdef TURN_TIMEOUT_EN
  logic [TC_W-1:0] tc_q, tc_d;
`endif

  logic up_only, dn_only, mid_lane;

  assign up_only  = btn_up & ~btn_down;
  assign dn_only  = btn_down & ~btn_up;
  assign mid_lane = (lane_q != 3'd0) && (lane_q <= LAST_MID);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q  <= S_IDLE;
      p2_q   <= 1'b0;
      lane_q <= START_LANE;
      y_q    <= 10'(int'(START_LANE) * LANE_PITCH + Y_BASE);
      s1_q   <= 4'd0;
      s2_q   <= 4'd0;
      win_q  <= 2'b00;
      ts_q   <= 1'b0;
      hc_q   <= '0;
`ifdef TURN_TIMEOUT_EN
      tc_q   <= '0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      p2_q   <= p2_d;
      lane_q <= lane_d;
      y_q    <= y_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      win_q  <= win_d;
      ts_q   <= ts_d;
      hc_q   <= hc_d;
`ifdef TURN_TIMEOUT_EN
      tc_q   <= tc_d;
`endif
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    p2_d   = p2_q;
    lane_d = lane_q;
    s1_d   = s1_q;
    s2_d   = s2_q;
    win_d  = win_q;
    ts_d   = 1'b0;
    hc_d   = hc_q;
`ifdef TURN_TIMEOUT_EN
    tc_d   = tc_q;
`endif
    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          fsm_d  = S_PLAY;
          p2_d   = 1'b0;
          lane_d = START_LANE;
          ts_d   = 1'b1;
`ifdef TURN_TIMEOUT_EN
          tc_d   = '0;
`endif
        end
      end
      S_PLAY: begin
        // hit outranks a simultaneous goal move
        if (hit && mid_lane) begin
          fsm_d = S_HOLD;
          hc_d  = '0;
        end else if (up_only && lane_q == 3'd1) begin
          lane_d = 3'd0;
          fsm_d  = S_HOLD;
          hc_d   = '0;
          if (!p2_q) begin
            if (s1_q != WIN) s1_d = s1_q + 4'd1;
          end else begin
            if (s2_q != WIN) s2_d = s2_q + 4'd1;
          end
        end else begin
          if (up_only && lane_q != 3'd0) begin
            lane_d = lane_q - 3'd1;
          end else if (dn_only && lane_q != START_LANE) begin
            lane_d = lane_q + 3'd1;
          end
`ifdef TURN_TIMEOUT_EN
          if (tick) begin
            if (tc_q == TC_END) begin
              fsm_d = S_HOLD;
              hc_d  = '0;
            end else begin
              tc_d = tc_q + 1'b1;
            end
          end
`endif
        end
      end
      S_HOLD: begin
        if (tick) begin
          if (hc_q == HC_END) begin
            if (s1_q == WIN || s2_q == WIN) begin
              fsm_d = S_DONE;
              win_d = (s1_q == WIN) ? 2'b01 : 2'b10;
            end else begin
              fsm_d  = S_PLAY;
              p2_d   = ~p2_q;
              lane_d = START_LANE;
              ts_d   = 1'b1;
`ifdef TURN_TIMEOUT_EN
              tc_d   = '0;
`endif
            end
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      S_DONE: begin
      end
    endcase
    y_d = 10'(int'(lane_d) * LANE_PITCH + Y_BASE);
  end

  always_comb begin
    state = 2'b00;
    unique case (fsm_q)
      S_IDLE: state = 2'b00;
      S_PLAY,
      S_HOLD: state = {p2_q, ~p2_q};
      S_DONE: state = 2'b11;
    endcase
  end

  assign player_lane = lane_q;
  assign player_y    = y_q;
  assign block_run   = (fsm_q == S_PLAY);
  assign p1_score    = s1_q;
  assign p2_score    = s2_q;
  assign winner      = win_q;
  assign turn_start  = ts_q;

endmodule

// File: tb/tb_lane_game_sequencer.sv
// Bench for lane_game_sequencer: game-rule model plus directed play.
// Honours TURN_TIMEOUT_EN by building the DUT with TURN_TICKS=5.
module tb_lane_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick, start, btn_up, btn_down, hit;
  logic [1:0] state;
  logic [2:0] player_lane;
  logic [9:0] player_y;
  logic       block_run;
  logic [3:0] p1_score, p2_score;
  logic [1:0] winner;
  logic       turn_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef TURN_TIMEOUT_EN
  lane_game_sequencer #(.TURN_TICKS(5)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .hit(hit),
    .state(state), .player_lane(player_lane), .player_y(player_y),
    .block_run(block_run), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .turn_start(turn_start)
  );
`else
  lane_game_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .hit(hit),
    .state(state), .player_lane(player_lane), .player_y(player_y),
    .block_run(block_run), .p1_score(p1_score), .p2_score(p2_score),
    .winner(winner), .turn_start(turn_start)
  );
`endif

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  int m_mode, m_ply, m_lane, m_hc, m_win, m_tt;
  int m_sc[3];
  bit m_ts, m_valid = 0;
`ifdef TURN_TIMEOUT_EN
  localparam int TT = 5;
`endif

  always @(posedge clk) begin
    m_ts = 0;
    if (!reset) begin
      m_mode = 0; m_ply = 1; m_lane = 7; m_hc = 0; m_win = 0;
      m_sc[1] = 0; m_sc[2] = 0; m_tt = 0; m_valid = 1;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode = 1; m_ply = 1; m_lane = 7; m_ts = 1; m_tt = 0;
        end
        1: begin
          if (hit && m_lane >= 1 && m_lane <= 6) begin
            m_mode = 2; m_hc = 0;
          end else if (btn_up && !btn_down && m_lane == 1) begin
            m_lane = 0; m_mode = 2; m_hc = 0;
            if (m_sc[m_ply] < 10) m_sc[m_ply]++;
          end else begin
            if (btn_up && !btn_down && m_lane > 0) m_lane--;
            else if (btn_down && !btn_up && m_lane < 7) m_lane++;
`ifdef TURN_TIMEOUT_EN
            if (tick) begin
              m_tt++;
              if (m_tt == TT) begin m_mode = 2; m_hc = 0; end
            end
`endif
          end
        end
        2: if (tick) begin
          m_hc++;
          if (m_hc == 32) begin
            if (m_sc[1] == 10 || m_sc[2] == 10) begin
              m_mode = 3; m_win = (m_sc[1] == 10) ? 1 : 2;
            end else begin
              m_ply = 3 - m_ply; m_lane = 7; m_mode = 1;
              m_ts = 1; m_tt = 0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", int'(state),
          m_mode == 0 ? 0 : (m_mode == 3 ? 3 : m_ply));
      chk("lane", int'(player_lane), m_lane);
      chk("y", int'(player_y), m_lane * 60);
      chk("block_run", int'(block_run), int'(m_mode == 1));
      chk("p1_score", int'(p1_score), m_sc[1]);
      chk("p2_score", int'(p2_score), m_sc[2]);
      chk("winner", int'(winner), m_win);
      chk("turn_start", int'(turn_start), int'(m_ts));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_up();
    btn_up = 1; step(); btn_up = 0; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1; step(); tick = 0; step();
    end
  endtask

  task automatic do_reset();
    reset = 0; step(); step(); reset = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; tick = 0; start = 0;
    btn_up = 0; btn_down = 0; hit = 0;
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_y", int'(player_y), 420);

    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) pulse_up();
    chk("lane3", int'(player_lane), 3);
    do_reset();
    chk("rst2_lane", int'(player_lane), 7);
    chk("rst2_y", int'(player_y), 420);
    chk("rst2_run", int'(block_run), 0);

    start = 1; step(); start = 0;
    chk("start_ts", int'(turn_start), 1);
    chk("start_state", int'(state), 1);
    step();
    chk("ts_once", int'(turn_start), 0);
    for (int i = 0; i < 7; i++) pulse_up();
    chk("goal_p1", int'(p1_score), 1);
    chk("goal_run", int'(block_run), 0);
    ticks(32);
    chk("p2_turn", int'(state), 2);
    chk("p2_lane", int'(player_lane), 7);

    for (int i = 0; i < 3; i++) pulse_up();
    hit = 1; btn_up = 1; step(); hit = 0; btn_up = 0; step();
    chk("hit_lane", int'(player_lane), 4);
    chk("hit_p2", int'(p2_score), 0);
    pulse_up();
    chk("hold_lane", int'(player_lane), 4);
    ticks(32);
    chk("back_p1", int'(state), 1);

    btn_up = 1; btn_down = 1; step(); btn_up = 0; btn_down = 0; step();
    btn_down = 1; step(); btn_down = 0; step();
    chk("sat_lane", int'(player_lane), 7);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 7; i++) pulse_up();
      ticks(32);
      hit = 1; step(); hit = 0; step();
      pulse_up();
      hit = 1; step(); hit = 0; step();
      ticks(32);
    end
    chk("p1_nine", int'(p1_score), 9);
    for (int i = 0; i < 7; i++) pulse_up();
    chk("p1_ten", int'(p1_score), 10);
    ticks(32);
    chk("done_state", int'(state), 3);
    chk("done_win", int'(winner), 1);
    start = 1; hit = 1; pulse_up(); start = 0; hit = 0;
    ticks(3);
    chk("done_hold", int'(state), 3);
    chk("done_p1", int'(p1_score), 10);

`ifdef TURN_TIMEOUT_EN
    do_reset();
    start = 1; step(); start = 0;
    ticks(5);
    chk("to_run", int'(block_run), 0);
    chk("to_p1", int'(p1_score), 0);
    ticks(32);
    chk("to_p2", int'(state), 2);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_game_sequencer.md
Name: lane_game_sequencer

Overview:
Game-flow controller for the two-player lane-crossing VGA game. It sequences idle → alternating player turns → done. It owns the player lane position derived from button pulses and gates block motion. It consumes a collision flag from the external detector and keeps both scores up to the win threshold. Its outputs drive the pixel generator (player_y, block_run) and the LED/SSD status logic (state, scores, winner).

Parameters:
NUM_LANES, 6, number of block lanes; lane index range 0..NUM_LANES+1, with NUM_LANES+1 ≤ 7
LANE_PITCH, 60, vertical pixels per lane
Y_BASE, 0, player_y of lane 0
WIN_SCORE, 10, score that ends the game (≤ 15)
HOLD_TICKS, 32, ticks frozen after a hit or score before the turn passes

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-low reset, sampled on rising clk
tick  in  1  one-cycle game-step enable (slow divider strobe)
start  in  1  level; begin game from idle
btn_up  in  1  one-cycle debounced pulse
btn_down  in  1  one-cycle debounced pulse
hit  in  1  collision detector output, valid every clk
state  out  2  00 idle, 01 player-1 turn, 10 player-2 turn, 11 done
player_lane  out  3  current lane index (0 = goal, NUM_LANES+1 = start)
player_y  out  10  player_lane*LANE_PITCH + Y_BASE, registered with player_lane
block_run  out  1  high while blocks may advance
p1_score  out  4  player-1 score
p2_score  out  4  player-2 score
winner  out  2  00 none, 01 P1, 10 P2; valid in DONE
turn_start  out  1  one-cycle pulse at start of each turn

Behaviour:
- Reset (reset==0 at a clk edge) overrides everything, including mid-turn or mid-hold. Reset values: internal FSM IDLE, cur_player=P1, player_lane=NUM_LANES+1, player_y=(NUM_LANES+1)*LANE_PITCH+Y_BASE (420 by default), scores 0, winner 00, block_run 0, turn_start 0, hold counter 0.
- Internal FSM: IDLE, PLAY, HOLD, DONE. The state output is 00 in IDLE, {cur_player==P2, cur_player==P1} in PLAY/HOLD, and 11 in DONE.
- IDLE: when start==1, go to PLAY with cur_player=P1 and lane=NUM_LANES+1. Pulse turn_start in the cycle PLAY is entered.
- PLAY: block_run=1.
  - Move rules:
    - btn_up alone with lane>0: lane−1.
    - btn_down alone with lane<NUM_LANES+1: lane+1.
    - Both pulses in the same cycle: ignored.
    - Moves beyond the bounds: ignored (saturate, no wrap).
  - Moves take effect on the next clk, independent of tick.
  - hit==1 while lane is in 1..NUM_LANES: go to HOLD with no score.
  - hit is ignored in lanes 0 and NUM_LANES+1.
  - A move into lane 0: increment the current player's score by 1 and go to HOLD.
  - If hit and the goal move coincide in the same cycle, hit wins: no score, lane unchanged.
- HOLD: block_run=0 and lane frozen; button pulses are ignored.
  - The counter loads 0 on entry and counts ticks.
  - On the tick where count==HOLD_TICKS−1:
    - If either score == WIN_SCORE: go to DONE, set winner, turn_start stays low.
    - Otherwise: toggle cur_player, set lane=NUM_LANES+1, go to PLAY, pulse turn_start.
  - The win check uses the score already updated on HOLD entry.
- DONE: block_run=0; all outputs hold. Leave only via reset. start is ignored.
- Scores saturate at WIN_SCORE; there is no 4-bit wrap.
- player_y is computed from the registered next-lane value, so lane and y change on the same edge. Latency from button pulse to player_y update is 1 clk.

Optional Feature:
Macro TURN_TIMEOUT_EN.
- Defined: adds parameter TURN_TICKS (default 600) and a per-turn tick counter, cleared on PLAY entry. If PLAY lasts TURN_TICKS ticks without a hit or score, the turn is treated as a hit: go to HOLD with no score. If expiry coincides with hit or a goal move, hit/goal takes priority.
- Undefined: no counter exists and a turn lasts indefinitely.

Test Plan:
- Reset low for 2 clk while in PLAY at lane 3 → state 00, lane 7, player_y 420, scores 0, block_run 0.
- start=1 from idle → state 01, turn_start high exactly 1 clk, block_run 1. Then 7 btn_up pulses → lane 0 after the 7th, p1_score 1, block_run 0. After 32 ticks → state 10, lane 7, turn_start pulse.
- P2 at lane 4 asserts hit; on the same clk btn_up → no score, lane stays 4. After 32 ticks → state 01.
- btn_up and btn_down in the same cycle at lane 7 → lane 7. btn_down at lane 7 → lane 7. btn_up pulses during HOLD → lane unchanged.
- Preload p1_score 9 via play; P1 reaches goal → p1_score 10, HOLD. After 32 ticks → state 11, winner 01, block_run 0. Further start/btn/hit → no change.
- With TURN_TIMEOUT_EN and TURN_TICKS=5: P1 idles 5 ticks in lane 7 → HOLD, p1_score unchanged, then state 10.
